// File: rtl/s_axi_regfile.sv
// AXI4 single-beat slave register file: independent AW/W capture, byte-strobed commit,
// ID-tagged B/R responses, read-only slots backed by live status words.
module s_axi_regfile #(
  parameter int                  DATA_W    = 32,
  parameter int                  NUM_REGS  = 8,
  parameter int                  ID_W      = 4,
  parameter logic [NUM_REGS-1:0] RO_MASK   = '0,
  parameter logic [DATA_W-1:0]   RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       areset,
  input  logic [ID_W-1:0]            awid_i,
  input  logic [31:0]                awaddr_i,
  input  logic                       awvalid_i,
  output logic                       awready_o,
  input  logic [DATA_W-1:0]          wdata_i,
  input  logic [DATA_W/8-1:0]        wstrb_i,
  input  logic                       wlast_i,
  input  logic                       wvalid_i,
  output logic                       wready_o,
  output logic [ID_W-1:0]            bid_o,
  output logic [1:0]                 bresp_o,
  output logic                       bvalid_o,
  input  logic                       bready_i,
  input  logic [ID_W-1:0]            arid_i,
  input  logic [31:0]                araddr_i,
  input  logic                       arvalid_i,
  output logic                       arready_o,
  output logic [ID_W-1:0]            rid_o,
  output logic [DATA_W-1:0]          rdata_o,
  output logic [1:0]                 rresp_o,
  output logic                       rlast_o,
  output logic                       rvalid_o,
  input  logic                       rready_i,
  output logic [NUM_REGS*DATA_W-1:0] regs_o,
  input  logic [NUM_REGS*DATA_W-1:0] status_i
);

  localparam int STRB_W = DATA_W / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam int NPOW   = 1 << IDX_W;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic [DATA_W-1:0] regs     [NUM_REGS];
  logic [DATA_W-1:0] status_w [NUM_REGS];
  logic [NPOW-1:0]   ro_ext;

  logic              has_addr, has_data;
  logic [31:0]       aw_addr;
  logic [ID_W-1:0]   aw_id;
  logic [DATA_W-1:0] w_data;
  logic [STRB_W-1:0] w_strb;

  logic [31:0]       widx_full, ridx_full;
  logic [IDX_W-1:0]  widx, ridx;
  logic              w_ok, r_in_range, r_ro, commit, ar_hs;
  logic              unused_ok;

  assign ro_ext    = NPOW'(RO_MASK);
  assign unused_ok = wlast_i;

  genvar gi;
  for (gi = 0; gi < NUM_REGS; gi++) begin : g_flat
    assign regs_o[gi*DATA_W +: DATA_W] = regs[gi];
    assign status_w[gi]                = status_i[gi*DATA_W +: DATA_W];
  end

  assign awready_o = !has_addr;
  assign wready_o  = !has_data;
  assign arready_o = !rvalid_o;
  assign rlast_o   = 1'b1;

  // Write target decode from the held address; RO slots reject writes
  assign widx_full = aw_addr >> LSB;
  assign widx      = widx_full[IDX_W-1:0];
  assign w_ok      = (widx_full < 32'(NUM_REGS)) ? !ro_ext[widx] : 1'b0;
  assign commit    = has_addr && has_data && !bvalid_o;

  assign ridx_full  = araddr_i >> LSB;
  assign ridx       = ridx_full[IDX_W-1:0];
  assign r_in_range = ridx_full < 32'(NUM_REGS);
  assign r_ro       = r_in_range ? ro_ext[ridx] : 1'b0;
  assign ar_hs      = arvalid_i && arready_o;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      has_addr <= 1'b0;
      has_data <= 1'b0;
      aw_addr  <= '0;
      aw_id    <= '0;
      w_data   <= '0;
      w_strb   <= '0;
      bvalid_o <= 1'b0;
      bid_o    <= '0;
      bresp_o  <= OKAY;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
    end else begin
      if (awvalid_i && !has_addr) begin
        has_addr <= 1'b1;
        aw_addr  <= awaddr_i;
        aw_id    <= awid_i;
      end
      if (wvalid_i && !has_data) begin
        has_data <= 1'b1;
        w_data   <= wdata_i;
        w_strb   <= wstrb_i;
      end
      if (bvalid_o && bready_i) bvalid_o <= 1'b0;
      // Commit only once the previous B has drained; flags are set so no capture collides
      if (commit) begin
        has_addr <= 1'b0;
        has_data <= 1'b0;
        bvalid_o <= 1'b1;
        bid_o    <= aw_id;
        bresp_o  <= w_ok ? OKAY : SLVERR;
        if (w_ok) begin
          for (int b = 0; b < STRB_W; b++)
            if (w_strb[b]) regs[widx][b*8 +: 8] <= w_data[b*8 +: 8];
        end
      end
    end
  end

  // Read path: data sampled at the AR handshake edge, so a same-edge commit is not visible
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      rvalid_o <= 1'b0;
      rid_o    <= '0;
      rdata_o  <= '0;
      rresp_o  <= OKAY;
    end else if (ar_hs) begin
      rvalid_o <= 1'b1;
      rid_o    <= arid_i;
      rresp_o  <= r_in_range ? OKAY : SLVERR;
      if (!r_in_range)  rdata_o <= '0;
      else if (r_ro)    rdata_o <= status_w[ridx];
      else              rdata_o <= regs[ridx];
    end else if (rvalid_o && rready_i) begin
      rvalid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_s_axi_regfile.sv
// Directed bench for s_axi_regfile: 32-bit data, 8 registers, register 1 read-only.
module tb_s_axi_regfile;

  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 8;
  localparam int ID_W     = 4;
  localparam int FLAT_W   = NUM_REGS * DATA_W;

  logic              clk = 1'b0;
  logic              areset;
  logic [ID_W-1:0]   awid, arid, bid, rid;
  logic [31:0]       awaddr, araddr;
  logic              awvalid, awready, wvalid, wready, wlast;
  logic [DATA_W-1:0] wdata, rdata;
  logic [3:0]        wstrb;
  logic [1:0]        bresp, rresp;
  logic              bvalid, bready, rvalid, rready, rlast, arvalid, arready;
  logic [FLAT_W-1:0] regs, status;

  logic [DATA_W-1:0] exp_regs [NUM_REGS];
  int n_checks = 0;
  int n_fails  = 0;

  s_axi_regfile #(
    .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ID_W(ID_W),
    .RO_MASK(8'h02), .RESET_VAL(32'h0)
  ) dut (
    .clk(clk), .areset(areset),
    .awid_i(awid), .awaddr_i(awaddr), .awvalid_i(awvalid), .awready_o(awready),
    .wdata_i(wdata), .wstrb_i(wstrb), .wlast_i(wlast), .wvalid_i(wvalid), .wready_o(wready),
    .bid_o(bid), .bresp_o(bresp), .bvalid_o(bvalid), .bready_i(bready),
    .arid_i(arid), .araddr_i(araddr), .arvalid_i(arvalid), .arready_o(arready),
    .rid_o(rid), .rdata_o(rdata), .rresp_o(rresp), .rlast_o(rlast),
    .rvalid_o(rvalid), .rready_i(rready),
    .regs_o(regs), .status_i(status)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [FLAT_W-1:0] obs, input logic [FLAT_W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [FLAT_W-1:0] packed_exp();
    logic [FLAT_W-1:0] v;
    for (int i = 0; i < NUM_REGS; i++) v[i*DATA_W +: DATA_W] = exp_regs[i];
    return v;
  endfunction

  task automatic do_read(input string tag, input logic [31:0] addr, input logic [ID_W-1:0] id,
                         input logic [DATA_W-1:0] edata, input logic [1:0] eresp);
    araddr  = addr;
    arid    = id;
    arvalid = 1'b1;
    step(1);
    arvalid = 1'b0;
    chk({tag, "_rvalid"}, FLAT_W'(rvalid), FLAT_W'(1'b1));
    chk({tag, "_rdata"},  FLAT_W'(rdata),  FLAT_W'(edata));
    chk({tag, "_rresp"},  FLAT_W'(rresp),  FLAT_W'(eresp));
    chk({tag, "_rid"},    FLAT_W'(rid),    FLAT_W'(id));
    rready = 1'b1;
    step(1);
    rready = 1'b0;
    chk({tag, "_rdone"},  FLAT_W'(rvalid), FLAT_W'(1'b0));
  endtask

  task automatic b_accept(input string tag);
    bready = 1'b1;
    step(1);
    bready = 1'b0;
    chk({tag, "_bdone"}, FLAT_W'(bvalid), FLAT_W'(1'b0));
  endtask

  initial begin
    areset = 1'b1;
    awid = '0; awaddr = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b1; wvalid = 1'b0;
    bready = 1'b0; arid = '0; araddr = '0; arvalid = 1'b0; rready = 1'b0;
    status = '0;
    status[1*DATA_W +: DATA_W] = 32'hDEADBEEF;
    for (int i = 0; i < NUM_REGS; i++) exp_regs[i] = 32'h0;
    step(2);
    areset = 1'b0;
    step(1);

    chk("rst_awready", FLAT_W'(awready), FLAT_W'(1'b1));
    chk("rst_wready",  FLAT_W'(wready),  FLAT_W'(1'b1));
    chk("rst_arready", FLAT_W'(arready), FLAT_W'(1'b1));
    chk("rst_bvalid",  FLAT_W'(bvalid),  FLAT_W'(1'b0));
    chk("rst_rlast",   FLAT_W'(rlast),   FLAT_W'(1'b1));
    chk("rst_regs",    regs, packed_exp());
    do_read("rd0", 32'h0, 4'h5, 32'h0, 2'b00);

    // W three cycles ahead of AW
    wdata = 32'hA5A5A5A5; wstrb = 4'b0101; wvalid = 1'b1;
    step(1);
    wvalid = 1'b0;
    chk("wfirst_wready", FLAT_W'(wready), FLAT_W'(1'b0));
    step(2);
    awaddr = 32'h8; awid = 4'h3; awvalid = 1'b1;
    step(1);
    awvalid = 1'b0;
    chk("wfirst_nob", FLAT_W'(bvalid), FLAT_W'(1'b0));
    step(1);
    exp_regs[2] = 32'h00A500A5;
    chk("wfirst_bvalid", FLAT_W'(bvalid), FLAT_W'(1'b1));
    chk("wfirst_bid",    FLAT_W'(bid),    FLAT_W'(4'h3));
    chk("wfirst_bresp",  FLAT_W'(bresp),  FLAT_W'(2'b00));
    chk("wfirst_regs",   regs, packed_exp());
    b_accept("wfirst");
    do_read("rd2", 32'h8, 4'h9, 32'h00A500A5, 2'b00);

    // Out-of-range write and read
    awaddr = 32'h20; awid = 4'h6; awvalid = 1'b1;
    wdata = 32'hFFFFFFFF; wstrb = 4'hF; wvalid = 1'b1;
    step(1);
    awvalid = 1'b0; wvalid = 1'b0;
    chk("oor_nob", FLAT_W'(bvalid), FLAT_W'(1'b0));
    step(1);
    chk("oor_bvalid", FLAT_W'(bvalid), FLAT_W'(1'b1));
    chk("oor_bresp",  FLAT_W'(bresp),  FLAT_W'(2'b10));
    chk("oor_bid",    FLAT_W'(bid),    FLAT_W'(4'h6));
    chk("oor_regs",   regs, packed_exp());
    b_accept("oor");
    do_read("rdoor", 32'h20, 4'h1, 32'h0, 2'b10);

    // Read-only register 1
    awaddr = 32'h4; awid = 4'h2; awvalid = 1'b1;
    wdata = 32'h11111111; wstrb = 4'hF; wvalid = 1'b1;
    step(1);
    awvalid = 1'b0; wvalid = 1'b0;
    step(1);
    chk("ro_bresp", FLAT_W'(bresp), FLAT_W'(2'b10));
    chk("ro_regs",  regs, packed_exp());
    b_accept("ro");
    do_read("rdro", 32'h4, 4'hA, 32'hDEADBEEF, 2'b00);

    // Back-pressured B with a second write queued behind it
    awaddr = 32'hC; awid = 4'h4; awvalid = 1'b1;
    wdata = 32'h01020304; wstrb = 4'hF; wvalid = 1'b1;
    step(1);
    awvalid = 1'b0; wvalid = 1'b0;
    step(1);
    exp_regs[3] = 32'h01020304;
    chk("bp_w1_bvalid", FLAT_W'(bvalid), FLAT_W'(1'b1));
    awaddr = 32'h10; awid = 4'hB; awvalid = 1'b1;
    wdata = 32'hCAFEF00D; wstrb = 4'b1100; wvalid = 1'b1;
    step(1);
    awvalid = 1'b0; wvalid = 1'b0;
    chk("bp_awready", FLAT_W'(awready), FLAT_W'(1'b0));
    chk("bp_wready",  FLAT_W'(wready),  FLAT_W'(1'b0));
    step(3);
    chk("bp_bid_hold", FLAT_W'(bid),    FLAT_W'(4'h4));
    chk("bp_no_commit", regs, packed_exp());
    bready = 1'b1;
    step(1);
    bready = 1'b0;
    chk("bp_blow",    FLAT_W'(bvalid), FLAT_W'(1'b0));
    chk("bp_pending", regs, packed_exp());
    step(1);
    exp_regs[4] = 32'hCAFE0000;
    chk("bp_w2_bvalid", FLAT_W'(bvalid),  FLAT_W'(1'b1));
    chk("bp_w2_bid",    FLAT_W'(bid),     FLAT_W'(4'hB));
    chk("bp_w2_regs",   regs, packed_exp());
    chk("bp_awready2",  FLAT_W'(awready), FLAT_W'(1'b1));
    b_accept("bp_w2");

    // Reset with AW held and R pending
    awaddr = 32'h0; awid = 4'h7; awvalid = 1'b1;
    araddr = 32'hC; arid = 4'hC; arvalid = 1'b1;
    step(1);
    awvalid = 1'b0; arvalid = 1'b0;
    chk("pre_rst_awready", FLAT_W'(awready), FLAT_W'(1'b0));
    chk("pre_rst_rvalid",  FLAT_W'(rvalid),  FLAT_W'(1'b1));
    chk("pre_rst_rdata",   FLAT_W'(rdata),   FLAT_W'(32'h01020304));
    areset = 1'b1;
    #1;
    for (int i = 0; i < NUM_REGS; i++) exp_regs[i] = 32'h0;
    chk("arst_rvalid",  FLAT_W'(rvalid),  FLAT_W'(1'b0));
    chk("arst_arready", FLAT_W'(arready), FLAT_W'(1'b1));
    chk("arst_awready", FLAT_W'(awready), FLAT_W'(1'b1));
    chk("arst_wready",  FLAT_W'(wready),  FLAT_W'(1'b1));
    chk("arst_rdata",   FLAT_W'(rdata),   FLAT_W'(32'h0));
    chk("arst_rid",     FLAT_W'(rid),     FLAT_W'(4'h0));
    chk("arst_regs",    regs, packed_exp());
    step(2);
    areset = 1'b0;
    wdata = 32'h55555555; wstrb = 4'hF; wvalid = 1'b1;
    step(1);
    wvalid = 1'b0;
    step(3);
    chk("post_rst_nob",  FLAT_W'(bvalid), FLAT_W'(1'b0));
    chk("post_rst_regs", regs, packed_exp());

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
